command_credit_arbiter: RTL and testbench
=========================================

Name: command_credit_arbiter

Overview:
- Shares the single PSL command interface between NUM_REQ command-buffer requesters: WED, read, write, prefetch-read and prefetch-write.
- Round-robin scheduling, gated by PSL command credits (croom); assigns rolling tags; returns credits on responses.
- Sits between the per-class command buffers and command_out, inside the AFU control path.

Parameters:
- NUM_REQ, 5, number of requesters; index 0 = WED.
- CMD_WIDTH, 64, width of one packed command word (cmd code + address + size).
- TAG_WIDTH, 8, width of the issued tag; also the credit counter width.

Ports:
- clock  in  1  system clock.
- rstn  in  1  async active-low reset.
- enabled_in  in  1  job running; low forces drain.
- room_in  in  TAG_WIDTH  initial credits, sampled on the LOAD cycle.
- request_valid  in  NUM_REQ  requester i has a command at its buffer head.
- request_cmd  in  NUM_REQ*CMD_WIDTH  head commands; requester i at slice i.
- request_ack  out  NUM_REQ  one-hot pop strobe to the granted requester.
- command_valid  out  1  command issue strobe to PSL.
- command_word  out  CMD_WIDTH  issued command.
- command_tag  out  TAG_WIDTH  issued tag.
- response_valid  in  1  PSL response strobe; returns one credit.
- credits_out  out  TAG_WIDTH  current available credits.
- outstanding_out  out  TAG_WIDTH  commands issued but not yet responded to.
- credit_error  out  1  sticky: response received with outstanding == 0.
- arb_state_out  out  2  FSM state encoding, for the status register.

Behaviour:
- Reset (async, rstn low): all outputs 0; FSM = IDLE; rr pointer = 0; tag counter = 0.
- FSM IDLE(0) -> LOAD(1) when enabled_in = 1.
- FSM LOAD(1): credits <= room_in; next cycle -> RUN.
- FSM RUN(2) -> DRAIN(3) when enabled_in = 0.
- FSM DRAIN(3): no grants; -> IDLE when outstanding = 0; responses are still counted.
- Eligibility (RUN only): requester i is eligible iff request_valid[i] = 1, credits > 0, and request_ack[i] was not high in the current cycle. The last condition blocks double-issue while the buffer advances.
- Grant: the first eligible requester searching from the rr pointer upward, wrapping at NUM_REQ-1 -> 0. After a grant, rr pointer <= granted index + 1 (mod NUM_REQ).
- Issue latency: one cycle. The grant is registered; command_valid, command_word, command_tag and request_ack[g] are all high in the following cycle, each for exactly one cycle. At most one issue per cycle.
- Tag: command_tag = tag counter; the counter increments per issue and wraps 2^TAG_WIDTH-1 -> 0.
- Credits: -1 on issue, +1 on response_valid. Simultaneous issue + response leaves credits unchanged.
- outstanding mirrors credits: +1 on issue, -1 on response.
- credits = 0: no grant; requests are held, not dropped.
- Response while outstanding = 0: counters unchanged; credit_error <= 1 until reset.
- enabled_in low mid-RUN: an already-registered grant still completes; no new grants after that.
- With no eligible requester: command_valid = 0; command_word/command_tag hold their previous values.

Optional Feature:
- Macro: CMD_ARB_WED_PRIORITY_EN.
- Defined: requester 0 (WED) wins whenever it is eligible, regardless of the rr pointer; the rr pointer is not updated on WED grants. The other requesters rotate as normal.
- Undefined: pure round-robin across all NUM_REQ requesters.

Decomposition:
- Shared package ARB_PKG holds:
  - enum arb_state_t {IDLE, LOAD, RUN, DRAIN};
  - constants NUM_REQ_DEFAULT and CMD_WIDTH_DEFAULT;
  - requester index constants REQ_WED = 0, REQ_READ = 1, REQ_WRITE = 2, REQ_PF_READ = 3, REQ_PF_WRITE = 4.
- One sub-module, rr_priority_select: combinational; inputs are the eligible vector and the pointer; outputs are a one-hot grant and its index.

Test Plan:
- Basic issue: room_in = 4; enable; requesters 1..4 each valid, one command each -> 4 issues in order 1, 2, 3, 4, tags 0..3; credits 4 -> 0; then no issue while requests remain pending.
- Credit stall/release: credits = 0 with requester 2 valid; one response_valid -> requester 2 issues 2 cycles later; credits end at 0.
- Simultaneous events: issue and response_valid in the same cycle -> credits unchanged; outstanding unchanged.
- Fairness: all 5 requesters continuously valid, room_in = 64 -> grant sequence 0, 1, 2, 3, 4, 0, ...; no requester is granted twice within 5 issues.
- Drain: 3 outstanding; enabled_in drops -> no new issues; FSM stays DRAIN until the 3rd response, then IDLE.
- Error and reset: response with outstanding = 0 -> credit_error = 1 and sticky. Asserting rstn mid-RUN -> all outputs 0 asynchronously; tag counter restarts at 0.

Source files
------------

// File: rtl/command_credit_arbiter_pkg.sv
// command_credit_arbiter_pkg: shared FSM encoding, default sizes and requester indices.
package command_credit_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DRAIN = 2'd3} arb_state_t;
  localparam int NUM_REQ_DEFAULT   = 5;
  localparam int CMD_WIDTH_DEFAULT = 64;
  localparam int REQ_WED      = 0;
  localparam int REQ_READ     = 1;
  localparam int REQ_WRITE    = 2;
  localparam int REQ_PF_READ  = 3;
  localparam int REQ_PF_WRITE = 4;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: first eligible requester at or above the pointer, wrapping, as one-hot and index.
module rr_priority_select #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_elig,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_valid && i_elig[(int'(i_ptr) + k) % N]) begin
        o_valid = 1'b1;
        o_idx   = IW'((int'(i_ptr) + k) % N);
        o_grant[(int'(i_ptr) + k) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/command_credit_arbiter.sv
// command_credit_arbiter: credit-gated round-robin issue of buffered commands onto the PSL command port.
// Define CMD_ARB_WED_PRIORITY_EN to let requester 0 (WED) win whenever it is eligible.
module command_credit_arbiter
  import command_credit_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEFAULT,
  parameter int CMD_WIDTH = CMD_WIDTH_DEFAULT,
  parameter int TAG_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         rstn,
  input  logic                         enabled_in,
  input  logic [TAG_WIDTH-1:0]         room_in,
  input  logic [NUM_REQ-1:0]           request_valid,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] request_cmd,
  output logic [NUM_REQ-1:0]           request_ack,
  output logic                         command_valid,
  output logic [CMD_WIDTH-1:0]         command_word,
  output logic [TAG_WIDTH-1:0]         command_tag,
  input  logic                         response_valid,
  output logic [TAG_WIDTH-1:0]         credits_out,
  output logic [TAG_WIDTH-1:0]         outstanding_out,
  output logic                         credit_error,
  output logic [1:0]                   arb_state_out
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t           r_state, w_next;
  logic [IW-1:0]        r_ptr, w_sel_idx, w_idx, w_ptr_nxt;
  logic [NUM_REQ-1:0]   w_elig, w_sel_grant, w_onehot, r_ack;
  logic                 w_any, w_resp_ok, r_vld, r_err;
  logic [CMD_WIDTH-1:0] r_word;
  logic [TAG_WIDTH-1:0] r_tag, r_tag_cnt, r_credits, r_out;
  // a requester acked this cycle still shows its old head, so it is masked out
  assign w_elig    = (r_state == RUN && enabled_in && r_credits != '0) ? request_valid & ~r_ack : '0;
  assign w_resp_ok = response_valid && r_out != '0;
  rr_priority_select #(.N(NUM_REQ), .IW(IW)) u_sel (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_sel_grant),
    .o_idx   (w_sel_idx),
    .o_valid (w_any)
  );
`ifdef CMD_ARB_WED_PRIORITY_EN
  logic w_wed;
  assign w_wed     = w_elig[REQ_WED];
  assign w_onehot  = w_wed ? NUM_REQ'(1) << REQ_WED : w_sel_grant;
  assign w_idx     = w_wed ? IW'(REQ_WED) : w_sel_idx;
  assign w_ptr_nxt = w_wed ? r_ptr : (w_sel_idx == IW'(NUM_REQ - 1)) ? '0 : w_sel_idx + IW'(1);
`else
  assign w_onehot  = w_sel_grant;
  assign w_idx     = w_sel_idx;
  assign w_ptr_nxt = (w_sel_idx == IW'(NUM_REQ - 1)) ? '0 : w_sel_idx + IW'(1);
`endif
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_ack     <= '0;
      r_vld     <= 1'b0;
      r_word    <= '0;
      r_tag     <= '0;
      r_tag_cnt <= '0;
      r_credits <= '0;
      r_out     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_vld     <= w_any;
      r_ack     <= w_onehot;
      r_credits <= (r_state == LOAD) ? room_in : r_credits - TAG_WIDTH'(w_any) + TAG_WIDTH'(w_resp_ok);
      r_out     <= r_out + TAG_WIDTH'(w_any) - TAG_WIDTH'(w_resp_ok);
      if (response_valid && r_out == '0) r_err <= 1'b1;
      if (w_any) begin
        r_word    <= request_cmd[int'(w_idx)*CMD_WIDTH +: CMD_WIDTH];
        r_tag     <= r_tag_cnt;
        r_tag_cnt <= r_tag_cnt + TAG_WIDTH'(1);
        r_ptr     <= w_ptr_nxt;
      end
    end
  end
  always_comb begin
    w_next = (r_state == IDLE && enabled_in)  ? LOAD  :
             (r_state == LOAD)                ? RUN   :
             (r_state == RUN && !enabled_in)  ? DRAIN :
             (r_state == DRAIN && r_out == '0) ? IDLE : r_state;
  end
  always_comb begin
    request_ack     = r_ack;
    command_valid   = r_vld;
    command_word    = r_word;
    command_tag     = r_tag;
    credits_out     = r_credits;
    outstanding_out = r_out;
    credit_error    = r_err;
    arb_state_out   = r_state;
  end
endmodule

// File: tb/tb_command_credit_arbiter.sv
// tb_command_credit_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_command_credit_arbiter;
  logic         clock = 1'b0;
  logic         rstn, enabled_in, response_valid;
  logic [7:0]   room_in;
  logic [4:0]   request_valid, request_ack;
  logic [319:0] request_cmd;
  logic         command_valid, credit_error;
  logic [63:0]  command_word;
  logic [7:0]   command_tag, credits_out, outstanding_out;
  logic [1:0]   arb_state_out;
  int n_cmp = 0, n_fail = 0;
  int m_state, m_cred, m_out, m_ptr, m_tagcnt, m_gi;
  bit m_gv, m_err;
  logic [63:0] m_word;
  logic [7:0]  m_tag;
  int cnt[5];
  logic [63:0] hd[5];

  command_credit_arbiter dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .room_in(room_in),
    .request_valid(request_valid), .request_cmd(request_cmd), .request_ack(request_ack),
    .command_valid(command_valid), .command_word(command_word), .command_tag(command_tag),
    .response_valid(response_valid), .credits_out(credits_out), .outstanding_out(outstanding_out),
    .credit_error(credit_error), .arb_state_out(arb_state_out)
  );

  always #5 clock = ~clock;

  function automatic int oh_idx(logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v == 5'(1 << i)) return i;
    return -1;
  endfunction

  function automatic logic [4:0] exp_ack();
    return m_gv ? 5'(1 << m_gi) : 5'b0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cred = 0; m_out = 0; m_ptr = 0; m_tagcnt = 0; m_gi = 0;
    m_gv = 0; m_err = 0; m_word = '0; m_tag = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < 5; i++) begin
      request_valid[i] = cnt[i] > 0;
      request_cmd[i*64 +: 64] = hd[i];
    end
  endtask

  // one clock: predict the edge from the rules, advance, then pop the buffer just acked
  task automatic tick();
    int g, ns;
    bit ok;
    drive();
    g = -1;
    if (m_state == 2 && enabled_in && m_cred > 0) begin
`ifdef CMD_ARB_WED_PRIORITY_EN
      if (cnt[0] > 0 && !(m_gv && m_gi == 0)) g = 0;
`endif
      for (int k = 0; k < 5 && g < 0; k++)
        if (cnt[(m_ptr + k) % 5] > 0 && !(m_gv && m_gi == (m_ptr + k) % 5)) g = (m_ptr + k) % 5;
    end
    ok = response_valid && m_out > 0;
    if (response_valid && m_out == 0) m_err = 1;
    ns = (m_state == 0 && enabled_in) ? 1 : (m_state == 1) ? 2 :
         (m_state == 2 && !enabled_in) ? 3 : (m_state == 3 && m_out == 0) ? 0 : m_state;
    m_cred = (m_state == 1) ? int'(room_in) : (m_cred - (g >= 0 ? 1 : 0) + (ok ? 1 : 0)) & 255;
    m_out = (m_out + (g >= 0 ? 1 : 0) - (ok ? 1 : 0)) & 255;
    m_state = ns;
    m_gv = g >= 0;
    if (g >= 0) begin
      m_gi = g;
      m_word = hd[g];
      m_tag = 8'(m_tagcnt);
      m_tagcnt = (m_tagcnt + 1) % 256;
`ifdef CMD_ARB_WED_PRIORITY_EN
      if (g != 0) m_ptr = (g + 1) % 5;
`else
      m_ptr = (g + 1) % 5;
`endif
    end
    @(posedge clock);
    @(negedge clock);
    if (m_gv) begin
      cnt[m_gi]--;
      hd[m_gi] = {$urandom, $urandom};
    end
  endtask

  task automatic sync_reset_pulse();
    @(negedge clock);
    rstn = 1'b0;
    model_reset();
    @(negedge clock);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enabled_in = 1'b0; response_valid = 1'b0; room_in = '0;
    for (int i = 0; i < 5; i++) begin cnt[i] = 0; hd[i] = {$urandom, $urandom}; end
    model_reset();
    drive();
    repeat (2) @(negedge clock);
    n_cmp++; if (command_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", command_valid); end
    n_cmp++; if (request_ack !== 5'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", request_ack); end
    n_cmp++; if (command_word !== 64'b0 || command_tag !== 8'b0) begin n_fail++; $display("FAIL reset_word_tag: got %h/%h expected 0/0", command_word, command_tag); end
    n_cmp++; if (credits_out !== 8'b0 || outstanding_out !== 8'b0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", credits_out, outstanding_out); end
    n_cmp++; if (credit_error !== 1'b0 || arb_state_out !== 2'd0) begin n_fail++; $display("FAIL reset_err_state: got %b/%0d expected 0/0", credit_error, arb_state_out); end
    rstn = 1'b1;
  endtask

  task automatic test_basic_issue();
    int seq[$], tags[$];
    room_in = 8'd4; enabled_in = 1'b1;
    for (int i = 1; i < 5; i++) cnt[i] = 1;
    repeat (12) begin
      tick();
      n_cmp++; if (command_valid !== m_gv || credits_out !== 8'(m_cred)) begin n_fail++; $display("FAIL basic_model: got v=%b c=%0d expected v=%b c=%0d", command_valid, credits_out, m_gv, m_cred); end
      if (command_valid === 1'b1) begin
        seq.push_back(oh_idx(request_ack));
        tags.push_back(int'(command_tag));
        n_cmp++; if (command_word !== m_word) begin n_fail++; $display("FAIL basic_word: got %h expected %h", command_word, m_word); end
      end
    end
    n_cmp++; if (seq.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", seq.size()); end
    for (int k = 0; k < 4 && k < seq.size(); k++) begin
      n_cmp++; if (seq[k] != k + 1 || tags[k] != k) begin n_fail++; $display("FAIL basic_order[%0d]: got req %0d tag %0d expected req %0d tag %0d", k, seq[k], tags[k], k + 1, k); end
    end
    n_cmp++; if (credits_out !== 8'd0 || outstanding_out !== 8'd4) begin n_fail++; $display("FAIL basic_credits: got %0d/%0d expected 0/4", credits_out, outstanding_out); end
    cnt[2] = 1;
    repeat (3) begin
      tick();
      n_cmp++; if (command_valid !== 1'b0) begin n_fail++; $display("FAIL basic_hold: got %b expected 0", command_valid); end
    end
  endtask

  task automatic test_credit_stall();
    response_valid = 1'b1;
    tick();
    response_valid = 1'b0;
    n_cmp++; if (command_valid !== 1'b0 || credits_out !== 8'd1) begin n_fail++; $display("FAIL stall_resp: got v=%b c=%0d expected v=0 c=1", command_valid, credits_out); end
    tick();
    n_cmp++; if (command_valid !== 1'b1 || request_ack !== 5'b00100) begin n_fail++; $display("FAIL stall_issue: got v=%b ack=%b expected v=1 ack=00100", command_valid, request_ack); end
    n_cmp++; if (command_tag !== 8'd4 || credits_out !== 8'd0 || outstanding_out !== 8'd4) begin n_fail++; $display("FAIL stall_after: got tag=%0d c=%0d o=%0d expected 4/0/4", command_tag, credits_out, outstanding_out); end
  endtask

  task automatic test_simultaneous();
    response_valid = 1'b1;
    tick();
    n_cmp++; if (credits_out !== 8'd1 || outstanding_out !== 8'd3) begin n_fail++; $display("FAIL simul_pre: got %0d/%0d expected 1/3", credits_out, outstanding_out); end
    cnt[3] = 1;
    tick();
    response_valid = 1'b0;
    n_cmp++; if (command_valid !== 1'b1 || request_ack !== 5'b01000) begin n_fail++; $display("FAIL simul_issue: got v=%b ack=%b expected v=1 ack=01000", command_valid, request_ack); end
    n_cmp++; if (credits_out !== 8'd1 || outstanding_out !== 8'd3) begin n_fail++; $display("FAIL simul_counts: got %0d/%0d expected 1/3", credits_out, outstanding_out); end
  endtask

  task automatic test_drain();
    enabled_in = 1'b0; cnt[4] = 1;
    tick();
    n_cmp++; if (arb_state_out !== 2'd3 || command_valid !== 1'b0) begin n_fail++; $display("FAIL drain_enter: got st=%0d v=%b expected 3/0", arb_state_out, command_valid); end
    response_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tick();
      n_cmp++; if (arb_state_out !== 2'd3 || command_valid !== 1'b0 || outstanding_out !== 8'(2 - r)) begin n_fail++; $display("FAIL drain_resp[%0d]: got st=%0d v=%b o=%0d expected 3/0/%0d", r, arb_state_out, command_valid, outstanding_out, 2 - r); end
    end
    response_valid = 1'b0;
    tick();
    n_cmp++; if (arb_state_out !== 2'd0 || credits_out !== 8'd4) begin n_fail++; $display("FAIL drain_idle: got st=%0d c=%0d expected 0/4", arb_state_out, credits_out); end
    cnt[4] = 0;
  endtask

  task automatic test_error();
    response_valid = 1'b1;
    tick();
    response_valid = 1'b0;
    n_cmp++; if (credit_error !== 1'b1 || outstanding_out !== 8'd0 || credits_out !== 8'd4) begin n_fail++; $display("FAIL error_set: got e=%b o=%0d c=%0d expected 1/0/4", credit_error, outstanding_out, credits_out); end
    repeat (3) tick();
    n_cmp++; if (credit_error !== 1'b1) begin n_fail++; $display("FAIL error_sticky: got %b expected 1", credit_error); end
  endtask

  task automatic test_fairness();
    int k = 0, last[$];
    sync_reset_pulse();
    room_in = 8'd64; enabled_in = 1'b1;
    for (int i = 0; i < 5; i++) cnt[i] = 1000;
    repeat (30) begin
      tick();
      if (command_valid === 1'b1) begin
        n_cmp++; if (oh_idx(request_ack) != m_gi || !m_gv) begin n_fail++; $display("FAIL fair_model[%0d]: got %0d expected %0d", k, oh_idx(request_ack), m_gi); end
`ifndef CMD_ARB_WED_PRIORITY_EN
        n_cmp++; if (oh_idx(request_ack) != k % 5) begin n_fail++; $display("FAIL fair_order[%0d]: got %0d expected %0d", k, oh_idx(request_ack), k % 5); end
        foreach (last[j]) if (last[j] == oh_idx(request_ack)) begin n_fail++; $display("FAIL fair_window[%0d]: got repeat of %0d expected none", k, last[j]); end
        n_cmp++;
`endif
        last.push_back(oh_idx(request_ack));
        if (last.size() > 4) void'(last.pop_front());
        k++;
      end
    end
    n_cmp++; if (k < 25) begin n_fail++; $display("FAIL fair_count: got %0d expected >=25", k); end
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (command_valid !== 1'b0 || request_ack !== 5'b0 || credits_out !== 8'b0 || outstanding_out !== 8'b0) begin n_fail++; $display("FAIL async_counters: got v=%b a=%b c=%0d o=%0d expected all 0", command_valid, request_ack, credits_out, outstanding_out); end
    n_cmp++; if (command_tag !== 8'b0 || command_word !== 64'b0 || arb_state_out !== 2'd0 || credit_error !== 1'b0) begin n_fail++; $display("FAIL async_regs: got t=%0d w=%h s=%0d e=%b expected all 0", command_tag, command_word, arb_state_out, credit_error); end
    model_reset();
    @(negedge clock);
    rstn = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (command_valid === 1'b1) begin
        seen = 1;
        n_cmp++; if (command_tag !== 8'd0 || request_ack !== 5'b00001) begin n_fail++; $display("FAIL async_restart: got tag=%0d ack=%b expected 0/00001", command_tag, request_ack); end
      end
    end
    if (!seen) begin n_cmp++; n_fail++; $display("FAIL async_timeout: got no issue expected one within 10 cycles"); end
  endtask

  task automatic test_random();
    sync_reset_pulse();
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    enabled_in = 1'b1;
    for (int c = 0; c < 400; c++) begin
      room_in = 8'($urandom_range(1, 8));
      if ($urandom % 4 == 0) cnt[$urandom % 5] += int'($urandom_range(1, 3));
      response_valid = (m_out > 0) ? ($urandom % 3 == 0) : ($urandom % 25 == 0);
      if ($urandom % 50 == 0) enabled_in = ~enabled_in;
      tick();
      n_cmp++; if (command_valid !== m_gv || request_ack !== exp_ack()) begin n_fail++; $display("FAIL rand_issue[%0d]: got v=%b a=%b expected v=%b a=%b", c, command_valid, request_ack, m_gv, exp_ack()); end
      n_cmp++; if (command_word !== m_word || command_tag !== m_tag) begin n_fail++; $display("FAIL rand_word[%0d]: got %h/%0d expected %h/%0d", c, command_word, command_tag, m_word, m_tag); end
      n_cmp++; if (credits_out !== 8'(m_cred) || outstanding_out !== 8'(m_out)) begin n_fail++; $display("FAIL rand_counts[%0d]: got %0d/%0d expected %0d/%0d", c, credits_out, outstanding_out, m_cred, m_out); end
      n_cmp++; if (credit_error !== m_err || arb_state_out !== 2'(m_state)) begin n_fail++; $display("FAIL rand_state[%0d]: got e=%b s=%0d expected e=%b s=%0d", c, credit_error, arb_state_out, m_err, m_state); end
    end
    response_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_credit_stall();
    test_simultaneous();
    test_drain();
    test_error();
    test_fairness();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
